// File: rtl/qbus_dma_grant_pkg.sv
// Shared types and defaults for the QBUS DMA grant handshake.
// All bus signals are active-high internal sense; the pad drivers invert them.
package qbus_dma_grant_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PASS     = 3'd1,
    S_REQ      = 3'd2,
    S_SACK     = 3'd3,
    S_WAIT_BUS = 3'd4,
    S_MASTER   = 3'd5,
    S_RELEASE  = 3'd6,
    S_ABORT    = 3'd7
  } state_t;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_DESKEW_CYCLES = 4;
  localparam int DEF_SACK_TIMEOUT  = 255;

endpackage

// File: rtl/qbus_dma_grant_if.sv
// Device-side and bus-side signals of one QBUS DMA slot.
// master: the grant block; slave: the device/bus environment around it.
interface qbus_dma_grant_if;
  logic dev_req;
  logic dev_done;
  logic dev_master;
  logic dev_abort;
  logic bus_dmr;
  logic bus_dmgi;
  logic bus_dmgo;
  logic bus_sack;
  logic bus_bbsy_in;
  logic bus_sync_in;
  logic bus_bbsy;

  modport master (
    input  dev_req, dev_done, bus_dmgi, bus_bbsy_in, bus_sync_in,
    output dev_master, dev_abort, bus_dmr, bus_dmgo, bus_sack, bus_bbsy
  );

  modport slave (
    output dev_req, dev_done, bus_dmgi, bus_bbsy_in, bus_sync_in,
    input  dev_master, dev_abort, bus_dmr, bus_dmgo, bus_sack, bus_bbsy
  );
endinterface

// File: rtl/qbus_dma_grant_bus_sync.sv
// Synchronizer for one asynchronous bus input, cleared to 0 on reset.
// Latency: STAGES cycles from input change to q.
// Backpressure: none; free-running flop chain.
module qbus_dma_grant_bus_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (reset) ff <= '0;
    else       ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/qbus_dma_grant.sv
// Per-slot QBUS DMA mastership: pass DMG downstream or take it via SACK/BBSY.
// Latency: SYNC_STAGES+1 cycles from a bus input edge to the output reaction.
// Backpressure: device holds dev_req until dev_master; no hold-off inside a tenure.
module qbus_dma_grant
  import qbus_dma_grant_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int DESKEW_CYCLES = DEF_DESKEW_CYCLES,
  parameter int SACK_TIMEOUT  = DEF_SACK_TIMEOUT
) (
  input logic             clk,
  input logic             reset,
  qbus_dma_grant_if.master bus
);

  localparam int             DW      = $clog2(DESKEW_CYCLES + 1);
  localparam logic [DW-1:0]  DSK_MAX = DW'(DESKEW_CYCLES);
  localparam logic [7:0]     TMO_MAX = 8'(SACK_TIMEOUT);

  logic dmg;
  logic bbsy_s;
  logic sync_s;

  qbus_dma_grant_bus_sync #(.STAGES(SYNC_STAGES)) u_sync_dmg (
    .clk(clk), .reset(reset), .d(bus.bus_dmgi), .q(dmg)
  );
  qbus_dma_grant_bus_sync #(.STAGES(SYNC_STAGES)) u_sync_bbsy (
    .clk(clk), .reset(reset), .d(bus.bus_bbsy_in), .q(bbsy_s)
  );
  qbus_dma_grant_bus_sync #(.STAGES(SYNC_STAGES)) u_sync_sync (
    .clk(clk), .reset(reset), .d(bus.bus_sync_in), .q(sync_s)
  );

  state_t        state, state_nxt;
  logic [DW-1:0] dsk_cnt, dsk_nxt;
  logic [7:0]    tmo_cnt, tmo_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      dsk_cnt <= '0;
      tmo_cnt <= '0;
    end else begin
      state   <= state_nxt;
      dsk_cnt <= dsk_nxt;
      tmo_cnt <= tmo_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dsk_nxt   = dsk_cnt;
    tmo_nxt   = tmo_cnt;
    case (state)
      // A grant seen while idle belongs to an upstream request, so passing wins.
      S_IDLE: begin
        if (dmg)              state_nxt = S_PASS;
        else if (bus.dev_req) state_nxt = S_REQ;
      end
      S_PASS: begin
        if (!dmg) state_nxt = S_IDLE;
      end
      S_REQ: begin
        if (dmg)               state_nxt = S_SACK;
        else if (!bus.dev_req) state_nxt = S_IDLE;
      end
      S_SACK: begin
        state_nxt = S_WAIT_BUS;
        dsk_nxt   = '0;
        tmo_nxt   = '0;
      end
      S_WAIT_BUS: begin
        if (dsk_cnt == DSK_MAX)      state_nxt = S_MASTER;
        else if (tmo_cnt == TMO_MAX) state_nxt = S_ABORT;
        // Bus must be quiet for the whole deskew window; any activity restarts it.
        if (dmg || bbsy_s || sync_s) dsk_nxt = '0;
        else if (dsk_cnt != DSK_MAX) dsk_nxt = dsk_cnt + DW'(1);
        if (tmo_cnt != TMO_MAX)      tmo_nxt = tmo_cnt + 8'd1;
      end
      S_MASTER: begin
        if (bus.dev_done) state_nxt = S_RELEASE;
      end
      S_RELEASE: state_nxt = S_IDLE;
      S_ABORT:   state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  assign bus.bus_dmgo   = (state == S_PASS);
  assign bus.bus_dmr    = (state == S_REQ);
  assign bus.bus_sack   = (state == S_SACK) || (state == S_WAIT_BUS);
  assign bus.bus_bbsy   = (state == S_MASTER);
  assign bus.dev_master = (state == S_MASTER);
  assign bus.dev_abort  = (state == S_ABORT);

endmodule

// File: tb/tb_qbus_dma_grant.sv
// Directed bench: stimulus pushes expected output changes with their cycle numbers,
// a negedge monitor pops one entry for every change of the output vector.
module tb_qbus_dma_grant;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  qbus_dma_grant_if bus_if ();

  qbus_dma_grant #(
    .SYNC_STAGES(2), .DESKEW_CYCLES(4), .SACK_TIMEOUT(255)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus_if.master)
  );

  // {dev_master, dev_abort, bus_dmr, bus_dmgo, bus_sack, bus_bbsy}
  localparam logic [5:0] V_IDLE   = 6'b000000;
  localparam logic [5:0] V_PASS   = 6'b000100;
  localparam logic [5:0] V_REQ    = 6'b001000;
  localparam logic [5:0] V_SACK   = 6'b000010;
  localparam logic [5:0] V_MASTER = 6'b100001;
  localparam logic [5:0] V_ABORT  = 6'b010000;

  typedef struct {
    int         cyc;
    logic [5:0] v;
    string      name;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  logic [5:0] cur;
  logic [5:0] prev;

  function automatic logic [5:0] outv();
    return {bus_if.dev_master, bus_if.dev_abort, bus_if.bus_dmr,
            bus_if.bus_dmgo, bus_if.bus_sack, bus_if.bus_bbsy};
  endfunction

  task automatic push(input int c, input logic [5:0] v, input string name);
    exp_t x;
    x.cyc = c; x.v = v; x.name = name;
    sb.push_back(x);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      cur = outv();
      if (cur != prev) begin
        n_chk++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_change cyc=%0d got=%b required=no change", cyc, cur);
        end else begin
          e = sb.pop_front();
          if (e.cyc == cyc && e.v == cur) n_pass++;
          else $display("FAIL %s got cyc=%0d vec=%b required cyc=%0d vec=%b",
                        e.name, cyc, cur, e.cyc, e.v);
        end
        prev = cur;
      end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        n_chk++;
        $display("FAIL %s missing at cyc=%0d vec stays %b required vec=%b",
                 e.name, e.cyc, cur, e.v);
      end
      n_chk++;
      if (!(bus_if.bus_dmgo && bus_if.bus_sack) && (!bus_if.dev_master || bus_if.bus_bbsy))
        n_pass++;
      else
        $display("FAIL invariant cyc=%0d dmgo=%b sack=%b master=%b bbsy=%b required exclusive/implied",
                 cyc, bus_if.bus_dmgo, bus_if.bus_sack, bus_if.dev_master, bus_if.bus_bbsy);
    end
  end

  initial begin
    int t;
    reset = 1'b1;
    bus_if.dev_req = 0; bus_if.dev_done = 0; bus_if.bus_dmgi = 0;
    bus_if.bus_bbsy_in = 0; bus_if.bus_sync_in = 0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (outv() == V_IDLE) n_pass++;
    else $display("FAIL reset_outputs got=%b required=%b", outv(), V_IDLE);
    prev = V_IDLE;
    mon_en = 1'b1;
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: grant passed through while not requesting
    t = cyc;
    bus_if.bus_dmgi = 1; push(t + 3, V_PASS, "t1_dmgo_rise");
    wait_to(t + 10); bus_if.bus_dmgi = 0; push(t + 13, V_IDLE, "t1_dmgo_fall");
    wait_to(t + 16);

    // 2 + 5: full tenure, release, immediate re-request
    t = cyc;
    bus_if.dev_req = 1; push(t + 1, V_REQ, "t2_dmr");
    wait_to(t + 20); bus_if.bus_dmgi = 1; push(t + 23, V_SACK, "t2_sack");
    wait_to(t + 25); bus_if.bus_dmgi = 0; push(t + 32, V_MASTER, "t2_master");
    wait_to(t + 35); bus_if.dev_done = 1; push(t + 36, V_IDLE, "t5_release");
    wait_to(t + 36); bus_if.dev_done = 0; push(t + 38, V_REQ, "t5_rereq");
    wait_to(t + 40); bus_if.dev_req = 0; push(t + 41, V_IDLE, "t5_withdraw");
    wait_to(t + 44);

    // 3: busy bus then sync glitch at deskew=3 restarts the count
    t = cyc;
    bus_if.dev_req = 1; bus_if.bus_bbsy_in = 1; push(t + 1, V_REQ, "t3_dmr");
    wait_to(t + 2);  bus_if.bus_dmgi = 1; push(t + 5, V_SACK, "t3_sack");
    wait_to(t + 7);  bus_if.bus_dmgi = 0;
    wait_to(t + 32); bus_if.bus_bbsy_in = 0;
    wait_to(t + 35); bus_if.bus_sync_in = 1;
    wait_to(t + 36); bus_if.bus_sync_in = 0; push(t + 43, V_MASTER, "t3_master_after_glitch");
    wait_to(t + 45); bus_if.dev_done = 1; push(t + 46, V_IDLE, "t3_release");
    wait_to(t + 46); bus_if.dev_done = 0; bus_if.dev_req = 0;
    wait_to(t + 50);

    // 4: bus never frees -> SACK timeout abort
    t = cyc;
    bus_if.dev_req = 1; bus_if.bus_bbsy_in = 1; push(t + 1, V_REQ, "t4_dmr");
    wait_to(t + 2); bus_if.bus_dmgi = 1; push(t + 5, V_SACK, "t4_sack");
    wait_to(t + 7); bus_if.bus_dmgi = 0;
    push(t + 262, V_ABORT, "t4_abort"); push(t + 263, V_IDLE, "t4_abort_end");
    wait_to(t + 262); bus_if.dev_req = 0;
    wait_to(t + 264); bus_if.bus_bbsy_in = 0;
    wait_to(t + 268);

    // 6a: reset while master
    t = cyc;
    bus_if.dev_req = 1; push(t + 1, V_REQ, "t6_dmr");
    wait_to(t + 2);  bus_if.bus_dmgi = 1; push(t + 5, V_SACK, "t6_sack");
    wait_to(t + 7);  bus_if.bus_dmgi = 0; push(t + 14, V_MASTER, "t6_master");
    wait_to(t + 16); reset = 1; bus_if.dev_req = 0; push(t + 17, V_IDLE, "t6_reset_master");
    wait_to(t + 18); reset = 0;
    wait_to(t + 22);

    // 6b: reset while passing; grant still high re-passes after resync
    t = cyc;
    bus_if.bus_dmgi = 1; push(t + 3, V_PASS, "t6_pass");
    wait_to(t + 5);  reset = 1; push(t + 6, V_IDLE, "t6_reset_pass");
    wait_to(t + 6);  reset = 0; push(t + 9, V_PASS, "t6_pass_again");
    wait_to(t + 10); bus_if.bus_dmgi = 0; push(t + 13, V_IDLE, "t6_pass_end");
    wait_to(t + 16);

    // 6c: request and grant together in idle -> pass; no steal; request follows
    t = cyc;
    bus_if.bus_dmgi = 1;
    wait_to(t + 2);  bus_if.dev_req = 1; push(t + 3, V_PASS, "t6_pass_wins");
    wait_to(t + 6);  bus_if.bus_dmgi = 0; push(t + 9, V_IDLE, "t6_pass_drop");
    push(t + 10, V_REQ, "t6_req_after_pass");
    wait_to(t + 11); bus_if.dev_req = 0; push(t + 12, V_IDLE, "t6_req_withdraw");
    wait_to(t + 17);

    n_chk++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain got=%0d pending required=0", sb.size());
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
